// File: rtl/mod_pkg.sv
// Shared types and defaults for the mod-unit scheduler.
package mod_pkg;

  localparam int unsigned W              = 128;
  localparam int unsigned DEF_MAX_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mod_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (wrapping).
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx
);

  logic            found;
  logic [ID_W-1:0] pos;

  // Scan from ptr upward, wrapping at NREQ, and keep the first active request.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = ID_W'((32'(ptr) + k) % NREQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/mod_sched.sv
// Shares one repeated-subtraction mod unit between NREQ requesters with
// round-robin arbitration, b==0 rejection and a WAIT-state timeout.
module mod_sched #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned W          = mod_pkg::W,
  parameter int unsigned MAX_CYCLES = mod_pkg::DEF_MAX_CYCLES,
  parameter int unsigned ID_W       = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*W-1:0]  req_a,
  input  logic [NREQ*W-1:0]  req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [W-1:0]       rsp_res,
  output logic               rsp_err,
  output logic               mod_start,
  output logic [W-1:0]       mod_a,
  output logic [W-1:0]       mod_b,
  input  logic [W-1:0]       mod_res,
  input  logic               mod_valid
);
  import mod_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_CYCLES);

  state_t            state, state_nx;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   gidx;
  logic [W-1:0]      sel_a, sel_b;
  logic              timeout;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign sel_a   = req_a[32'(gidx)*W +: W];
  assign sel_b   = req_b[32'(gidx)*W +: W];
  assign timeout = (cnt == CNT_W'(MAX_CYCLES - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    mod_start = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|req_valid) state_nx = (sel_b == '0) ? RESP : START;
      end
      START: begin
        mod_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: begin
        if (mod_valid || timeout) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Job datapath: operand latch, cycle budget, result capture, pointer advance.
  // cnt is frozen on the exit cycle instead of incrementing so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      cnt     <= '0;
      rsp_id  <= '0;
      mod_a   <= '0;
      mod_b   <= '0;
      rsp_res <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            rsp_id <= gidx;
            mod_a  <= sel_a;
            mod_b  <= sel_b;
            if (sel_b == '0) begin
              rsp_err <= 1'b1;
              rsp_res <= '0;
            end
          end
        end
        START: cnt <= '0;
        WAIT: begin
          if (mod_valid) begin
            rsp_res <= mod_res;
            rsp_err <= 1'b0;
          end else if (timeout) begin
            rsp_err <= 1'b1;
            rsp_res <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready)
            rr_ptr <= (rsp_id == ID_W'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_sched.sv
// Self-checking bench for mod_sched with behavioural mod units.
module tb_mod_sched;
  localparam int W    = 128;
  localparam int NREQ = 4;

  typedef struct {
    int         id;
    logic [W-1:0] res;
    logic       err;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]   req_valid, req_valid2;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready, req_ready2;
  logic rsp_valid, rsp_valid2, rsp_ready, rsp_ready2;
  logic [1:0] rsp_id, rsp_id2;
  logic [W-1:0] rsp_res, rsp_res2;
  logic rsp_err, rsp_err2;
  logic mod_start, mod_start2;
  logic [W-1:0] mod_a, mod_b, mod_a2, mod_b2;
  logic [W-1:0] mr0 = '0, mb0 = '1, mr1 = '0, mb1 = '1;
  logic mv0 = 1'b0, mv1 = 1'b0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_sched #(.NREQ(NREQ), .W(W), .MAX_CYCLES(1024)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_err(rsp_err),
    .mod_start(mod_start), .mod_a(mod_a), .mod_b(mod_b),
    .mod_res(mr0), .mod_valid(mv0));

  mod_sched #(.NREQ(NREQ), .W(W), .MAX_CYCLES(8)) u_dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_id(rsp_id2), .rsp_res(rsp_res2), .rsp_err(rsp_err2),
    .mod_start(mod_start2), .mod_a(mod_a2), .mod_b(mod_b2),
    .mod_res(mr1), .mod_valid(mv1));

  // Behavioural repeated-subtraction units; no reset, reloaded on start.
  always @(posedge clk) begin
    if (mod_start) begin
      mr0 <= mod_a; mb0 <= mod_b; mv0 <= 1'b0;
    end else if (!mv0) begin
      if (mr0 >= mb0) mr0 <= mr0 - mb0;
      else            mv0 <= 1'b1;
    end
    if (mod_start2) begin
      mr1 <= mod_a2; mb1 <= mod_b2; mv1 <= 1'b0;
    end else if (!mv1) begin
      if (mr1 >= mb1) mr1 <= mr1 - mb1;
      else            mv1 <= 1'b1;
    end
  end

  task automatic issue(input int which, input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int t0, output logic [NREQ-1:0] rdy);
    @(negedge clk);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    if (which == 0) req_valid[r] = 1'b1;
    else            req_valid2[r] = 1'b1;
    #1;
    rdy = (which == 0) ? req_ready : req_ready2;
    t0  = cyc;
  endtask

  // Bounded wait for a response; reports what was seen, compares nothing.
  task automatic wait_rsp(input int which, input int t0, output bit seen, output int lat,
                          output int nstart, output int scyc, output logic [W-1:0] sa,
                          output logic [W-1:0] sbv, output int id, output logic [W-1:0] res,
                          output logic err);
    seen = 1'b0; lat = -1; nstart = 0; scyc = -1; sa = '0; sbv = '0; id = -1; res = '0; err = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      if (n == 0) begin req_valid = '0; req_valid2 = '0; end
      #1;
      if ((which == 0) ? mod_start : mod_start2) begin
        nstart++;
        scyc = cyc - t0;
        sa   = (which == 0) ? mod_a : mod_a2;
        sbv  = (which == 0) ? mod_b : mod_b2;
      end
      if ((which == 0) ? rsp_valid : rsp_valid2) begin
        seen = 1'b1;
        lat  = cyc - t0;
        id   = int'((which == 0) ? rsp_id : rsp_id2);
        res  = (which == 0) ? rsp_res : rsp_res2;
        err  = (which == 0) ? rsp_err : rsp_err2;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_valid2 = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; rsp_ready2 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_id, rsp_res, rsp_err} !== '0) begin
      miscompares++; $display("FAIL reset_rsp got rdy=%b v=%b id=%0d res=%0h err=%b exp all 0", req_ready, rsp_valid, rsp_id, rsp_res, rsp_err);
    end
    vectors++;
    if ({mod_start, mod_a, mod_b} !== '0) begin
      miscompares++; $display("FAIL reset_mod got start=%b a=%0h b=%0h exp 0", mod_start, mod_a, mod_b);
    end
    vectors++;
    if ({req_ready2, rsp_valid2, rsp_err2, mod_start2} !== '0) begin
      miscompares++; $display("FAIL reset_dut2 got rdy=%b v=%b err=%b start=%b exp 0", req_ready2, rsp_valid2, rsp_err2, mod_start2);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single();
    int t0, lat, ns, sc, id; bit seen; logic [NREQ-1:0] rdy; logic [W-1:0] sa, sbv, res; logic err; exp_t e;
    issue(0, 0, 10, 3, t0, rdy);
    vectors++;
    if (rdy !== 4'b0001) begin miscompares++; $display("FAIL single_ready got %b exp 0001", rdy); end
    sb.push_back('{0, 128'd1, 1'b0, 7});
    wait_rsp(0, t0, seen, lat, ns, sc, sa, sbv, id, res, err);
    e = sb.pop_front();
    vectors++;
    if (ns !== 1 || sc !== 1) begin miscompares++; $display("FAIL single_start got n=%0d at %0d exp 1 at 1", ns, sc); end
    vectors++;
    if (sa !== 128'd10 || sbv !== 128'd3) begin miscompares++; $display("FAIL single_oper got a=%0d b=%0d exp 10 3", sa, sbv); end
    vectors++;
    if (lat !== e.lat) begin miscompares++; $display("FAIL single_lat got %0d exp %0d", lat, e.lat); end
    vectors++;
    if (id !== e.id || res !== e.res || err !== e.err) begin
      miscompares++; $display("FAIL single_rsp got id=%0d res=%0d err=%b exp id=%0d res=%0d err=%b", id, res, err, e.id, e.res, e.err);
    end
  endtask

  task automatic test_a_lt_b();
    int t0, lat, ns, sc, id; bit seen; logic [NREQ-1:0] rdy; logic [W-1:0] sa, sbv, res; logic err; exp_t e;
    for (int k = 0; k < 2; k++) begin
      issue(0, 2, 5, 9, t0, rdy);
      vectors++;
      if (rdy !== 4'b0100) begin miscompares++; $display("FAIL altb_ready[%0d] got %b exp 0100", k, rdy); end
      sb.push_back('{2, 128'd5, 1'b0, 4});
      wait_rsp(0, t0, seen, lat, ns, sc, sa, sbv, id, res, err);
      e = sb.pop_front();
      vectors++;
      if (lat !== e.lat) begin miscompares++; $display("FAIL altb_lat[%0d] got %0d exp %0d", k, lat, e.lat); end
      vectors++;
      if (id !== e.id || res !== e.res || err !== e.err) begin
        miscompares++; $display("FAIL altb_rsp[%0d] got id=%0d res=%0d err=%b exp id=%0d res=%0d err=%b", k, id, res, err, e.id, e.res, e.err);
      end
    end
  endtask

  task automatic test_b_zero();
    int t0, lat, ns, sc, id; bit seen; logic [NREQ-1:0] rdy; logic [W-1:0] sa, sbv, res; logic err; exp_t e;
    issue(0, 1, 77, 0, t0, rdy);
    vectors++;
    if (rdy !== 4'b0010) begin miscompares++; $display("FAIL bzero_ready got %b exp 0010", rdy); end
    sb.push_back('{1, 128'd0, 1'b1, 1});
    wait_rsp(0, t0, seen, lat, ns, sc, sa, sbv, id, res, err);
    e = sb.pop_front();
    vectors++;
    if (ns !== 0) begin miscompares++; $display("FAIL bzero_start got %0d pulses exp 0", ns); end
    vectors++;
    if (lat !== e.lat || id !== e.id || res !== e.res || err !== e.err) begin
      miscompares++; $display("FAIL bzero_rsp got lat=%0d id=%0d res=%0d err=%b exp lat=%0d id=%0d res=%0d err=%b", lat, id, res, err, e.lat, e.id, e.res, e.err);
    end
  endtask

  task automatic test_timeout();
    int t0, lat, ns, sc, id; bit seen; logic [NREQ-1:0] rdy; logic [W-1:0] sa, sbv, res; logic err; exp_t e;
    issue(1, 0, 100, 1, t0, rdy);
    vectors++;
    if (rdy !== 4'b0001) begin miscompares++; $display("FAIL tmo_ready got %b exp 0001", rdy); end
    sb.push_back('{0, 128'd0, 1'b1, 10});
    wait_rsp(1, t0, seen, lat, ns, sc, sa, sbv, id, res, err);
    e = sb.pop_front();
    vectors++;
    if (lat !== e.lat || id !== e.id || res !== e.res || err !== e.err) begin
      miscompares++; $display("FAIL tmo_rsp got lat=%0d id=%0d res=%0d err=%b exp lat=%0d id=%0d res=%0d err=%b", lat, id, res, err, e.lat, e.id, e.res, e.err);
    end
    issue(1, 0, 7, 4, t0, rdy);
    sb.push_back('{0, 128'd3, 1'b0, 5});
    wait_rsp(1, t0, seen, lat, ns, sc, sa, sbv, id, res, err);
    e = sb.pop_front();
    vectors++;
    if (lat !== e.lat || id !== e.id || res !== e.res || err !== e.err) begin
      miscompares++; $display("FAIL tmo_next got lat=%0d id=%0d res=%0d err=%b exp lat=%0d id=%0d res=%0d err=%b", lat, id, res, err, e.lat, e.id, e.res, e.err);
    end
  endtask

  task automatic test_wait_reset();
    int t0, lat, ns, sc, id, nrsp; bit seen; logic [NREQ-1:0] rdy; logic [W-1:0] sa, sbv, res; logic err; exp_t e;
    issue(0, 3, 50, 7, t0, rdy);
    sb.push_back('{3, 128'd1, 1'b0, 11});
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    vectors++;
    if ({req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, mod_start, mod_a, mod_b} !== '0) begin
      miscompares++; $display("FAIL wrst_outs got v=%b start=%b a=%0d b=%0d res=%0d exp all 0", rsp_valid, mod_start, mod_a, mod_b, rsp_res);
    end
    @(negedge clk); rst = 1'b0;
    nrsp = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk); #1;
      if (rsp_valid) nrsp++;
    end
    vectors++;
    if (nrsp !== 0) begin miscompares++; $display("FAIL wrst_norsp got %0d responses exp 0", nrsp); end
    issue(0, 3, 50, 7, t0, rdy);
    vectors++;
    if (rdy !== 4'b1000) begin miscompares++; $display("FAIL wrst_ready got %b exp 1000", rdy); end
    sb.push_back('{3, 128'd1, 1'b0, 11});
    wait_rsp(0, t0, seen, lat, ns, sc, sa, sbv, id, res, err);
    e = sb.pop_front();
    vectors++;
    if (lat !== e.lat || id !== e.id || res !== e.res || err !== e.err) begin
      miscompares++; $display("FAIL wrst_rsp got lat=%0d id=%0d res=%0d err=%b exp lat=%0d id=%0d res=%0d err=%b", lat, id, res, err, e.lat, e.id, e.res, e.err);
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int naccept = 0, ndone = 0, hold = 0;
    bit drop = 1'b0;
    logic [NREQ-1:0] prev = '0;
    logic [NREQ-1:0] one = 4'b0001;
    logic [1:0] s_id; logic [W-1:0] s_res; logic s_err;
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'(20 + 3*i);
      req_b[i*W +: W] = W'(6);
    end
    rsp_ready = 1'b1;
    for (int n = 0; n < 400 && ndone < 5; n++) begin
      @(negedge clk);
      if (n == 0) req_valid = '1;
      if (drop) req_valid = '0;
      #1;
      if (req_ready != '0) begin
        vectors++;
        if (naccept >= 5 || req_ready !== (one << order[naccept]) || prev !== '0) begin
          miscompares++; $display("FAIL rr_grant[%0d] got %b prev=%b exp id %0d", naccept, req_ready, prev, (naccept < 5) ? order[naccept] : -1);
        end
        if (naccept < 5) begin
          e.id = order[naccept]; e.err = 1'b0; e.lat = -1;
          e.res = W'((20 + 3*order[naccept]) % 6);
          sb.push_back(e);
        end
        naccept++;
        if (naccept == 5) drop = 1'b1;
      end
      prev = req_ready;
      if (rsp_valid) begin
        if (ndone == 2 && hold < 5) begin
          if (hold == 0) begin
            rsp_ready = 1'b0; s_id = rsp_id; s_res = rsp_res; s_err = rsp_err;
          end else begin
            vectors++;
            if (rsp_id !== s_id || rsp_res !== s_res || rsp_err !== s_err || req_ready !== '0) begin
              miscompares++; $display("FAIL rr_hold[%0d] got id=%0d res=%0d err=%b rdy=%b exp id=%0d res=%0d err=%b rdy=0", hold, rsp_id, rsp_res, rsp_err, req_ready, s_id, s_res, s_err);
            end
          end
          hold++;
        end else begin
          rsp_ready = 1'b1;
          vectors++;
          if (sb.size() == 0) begin
            miscompares++; $display("FAIL rr_extra got id=%0d exp no response", rsp_id);
          end else begin
            e = sb.pop_front();
            if (int'(rsp_id) !== e.id || rsp_res !== e.res || rsp_err !== e.err) begin
              miscompares++; $display("FAIL rr_rsp[%0d] got id=%0d res=%0d err=%b exp id=%0d res=%0d err=%b", ndone, rsp_id, rsp_res, rsp_err, e.id, e.res, e.err);
            end
          end
          ndone++;
        end
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    vectors++;
    if (ndone !== 5 || naccept !== 5 || hold !== 5) begin
      miscompares++; $display("FAIL rr_count got done=%0d acc=%0d hold=%0d exp 5 5 5", ndone, naccept, hold);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_a_lt_b();
    test_b_zero();
    test_timeout();
    test_wait_reset();
    test_round_robin();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
